// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the convolution-tile sequencer.
package core_ctrl_pkg;

  localparam int ADDR_BW = 11;
  localparam int CNT_BW  = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_WREQ,
    ST_KLOAD,
    ST_KGAP,
    ST_ALOAD,
    ST_EXEC,
    ST_RDOUT,
    ST_DONE
  } state_t;

  localparam logic [1:0] INST_IDLE  = 2'b00;
  localparam logic [1:0] INST_KLOAD = 2'b01;
  localparam logic [1:0] INST_ALOAD = 2'b10;

  // Dwell counts are loaded as (count-1) into an 8-bit counter, so 1..255 is legal.
  function automatic bit cnt_in_range(input int v);
    return (v >= 1) && (v <= (1 << CNT_BW) - 1);
  endfunction

endpackage

// File: rtl/phase_cnt.sv
// Loadable down-counter that times every FSM dwell; sticks at zero until reloaded.
module phase_cnt
  import core_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [CNT_BW-1:0] i_load_val,
  output logic              o_zero
);

  logic [CNT_BW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_BW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/core_seq_ctrl.sv
// Sequencer walking the core through one 3x3 conv tile: per kij clear, weight
// handshake, kernel load, gap, activation load, drain; then a single readout.
module core_seq_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int                 len_kij     = 9,
  parameter int                 len_nij     = 36,
  parameter int                 len_onij    = 16,
  parameter int                 col         = 8,
  parameter logic [ADDR_BW-1:0] w_base      = 11'h400,
  parameter logic [ADDR_BW-1:0] x_base      = 11'h000,
  parameter int                 clr_cycles  = 11,
  parameter int                 kgap_cycles = 10,
  parameter int                 exec_cycles = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               w_ack,
  output logic               busy,
  output logic               done,
  output logic               w_req,
  output logic               core_clr,
  output logic               CEN_xmem,
  output logic               WEN_xmem,
  output logic [ADDR_BW-1:0] A_xmem,
  output logic [1:0]         inst_w,
  output logic [3:0]         kij,
  output logic               readout_start
);

  if (!cnt_in_range(len_kij) || !cnt_in_range(len_nij) || !cnt_in_range(len_onij) ||
      !cnt_in_range(col) || !cnt_in_range(clr_cycles) || !cnt_in_range(kgap_cycles) ||
      !cnt_in_range(exec_cycles) || (len_kij > 16)) begin : g_param_chk
    $error("core_seq_ctrl: count parameter outside 1..255 or len_kij exceeds kij width");
  end

  localparam logic [CNT_BW-1:0] LD_CLR   = CNT_BW'(clr_cycles - 1);
  localparam logic [CNT_BW-1:0] LD_KLOAD = CNT_BW'(col - 1);
  localparam logic [CNT_BW-1:0] LD_KGAP  = CNT_BW'(kgap_cycles - 1);
  localparam logic [CNT_BW-1:0] LD_ALOAD = CNT_BW'(len_nij - 1);
  localparam logic [CNT_BW-1:0] LD_EXEC  = CNT_BW'(exec_cycles - 1);
  // Readout dwells len_onij+1 cycles, hence no -1 here.
  localparam logic [CNT_BW-1:0] LD_RDOUT = CNT_BW'(len_onij);
  localparam logic [3:0]        KIJ_LAST = 4'(len_kij - 1);

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_w_req;
  logic               r_core_clr;
  logic               r_cen;
  logic [ADDR_BW-1:0] r_addr;
  logic [1:0]         r_inst;
  logic [3:0]         r_kij;
  logic               r_rd_start;

  logic               w_load;
  logic [CNT_BW-1:0]  w_load_val;
  logic               w_zero;

  phase_cnt u_phase_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  // Counter reload coincides with the state transition that starts each dwell.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    if (abort) begin
      w_load = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          w_load     = 1'b1;
          w_load_val = LD_CLR;
        end
        ST_WREQ: if (w_ack) begin
          w_load     = 1'b1;
          w_load_val = LD_KLOAD;
        end
        ST_KLOAD: if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = LD_KGAP;
        end
        ST_KGAP: if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = LD_ALOAD;
        end
        ST_ALOAD: if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = LD_EXEC;
        end
        ST_EXEC: if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = (r_kij < KIJ_LAST) ? LD_CLR : LD_RDOUT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_w_req    <= 1'b0;
      r_core_clr <= 1'b0;
      r_cen      <= 1'b1;
      r_addr     <= '0;
      r_inst     <= INST_IDLE;
      r_kij      <= '0;
      r_rd_start <= 1'b0;
    end else if (abort) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_w_req    <= 1'b0;
      r_core_clr <= 1'b0;
      r_cen      <= 1'b1;
      r_addr     <= '0;
      r_inst     <= INST_IDLE;
      r_kij      <= '0;
      r_rd_start <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rd_start <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_state    <= ST_CLR;
          r_busy     <= 1'b1;
          r_core_clr <= 1'b1;
          r_kij      <= '0;
        end
        ST_CLR: if (w_zero) begin
          r_state    <= ST_WREQ;
          r_core_clr <= 1'b0;
          r_w_req    <= 1'b1;
        end
        ST_WREQ: if (w_ack) begin
          r_state <= ST_KLOAD;
          r_w_req <= 1'b0;
          r_cen   <= 1'b0;
          r_inst  <= INST_KLOAD;
          r_addr  <= w_base;
        end
        ST_KLOAD: begin
          if (w_zero) begin
            r_state <= ST_KGAP;
            r_cen   <= 1'b1;
            r_inst  <= INST_IDLE;
            r_addr  <= '0;
          end else begin
            r_addr <= r_addr + ADDR_BW'(1);
          end
        end
        ST_KGAP: if (w_zero) begin
          r_state <= ST_ALOAD;
          r_cen   <= 1'b0;
          r_inst  <= INST_ALOAD;
          r_addr  <= x_base;
        end
        ST_ALOAD: begin
          if (w_zero) begin
            r_state <= ST_EXEC;
            r_cen   <= 1'b1;
            r_inst  <= INST_IDLE;
            r_addr  <= '0;
          end else begin
            r_addr <= r_addr + ADDR_BW'(1);
          end
        end
        ST_EXEC: if (w_zero) begin
          if (r_kij < KIJ_LAST) begin
            r_state    <= ST_CLR;
            r_kij      <= r_kij + 4'd1;
            r_core_clr <= 1'b1;
          end else begin
            r_state    <= ST_RDOUT;
            r_rd_start <= 1'b1;
          end
        end
        ST_RDOUT: if (w_zero) begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign w_req         = r_w_req;
  assign core_clr      = r_core_clr;
  assign CEN_xmem      = r_cen;
  assign WEN_xmem      = 1'b1;
  assign A_xmem        = r_addr;
  assign inst_w        = r_inst;
  assign kij           = r_kij;
  assign readout_start = r_rd_start;

endmodule
